// File: rtl/uart_rx.sv
// UART receiver: two-flop synchronizer, centre-sampled 8N1-style frames,
// valid/ready output register with framing-error and overrun pulses.
module uart_rx #(
  parameter int NUMBER_OF_BITS = 8,
  parameter int BAUD_DIVIDER   = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      rx,
  output logic                      data_valid,
  input  logic                      data_ready,
  output logic [NUMBER_OF_BITS-1:0] data_bits,
  output logic                      framing_error,
  output logic                      overrun
);

  localparam int HALF = BAUD_DIVIDER / 2;
  localparam int RW   = $clog2(BAUD_DIVIDER);
  localparam int IW   = $clog2(NUMBER_OF_BITS + 1);
  localparam int N    = NUMBER_OF_BITS;

  localparam logic [RW-1:0] RATE_HALF = RW'(HALF - 1);
  localparam logic [RW-1:0] RATE_FULL = RW'(BAUD_DIVIDER - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  logic [1:0]    sync;
  logic          rx_s;
  state_t        state, state_next;
  logic [RW-1:0] rate, rate_next;
  logic [IW-1:0] index, index_next;
  logic [N-1:0]  shift, shift_next;
  logic          deliver;
  logic          frame_bad;
  logic          tick;
  logic          load;

  assign rx_s = sync[1];
  assign tick = (rate == '0);
  assign load = deliver && (!data_valid || data_ready);

  always_comb begin
    state_next = state;
    rate_next  = rate;
    index_next = index;
    shift_next = shift;
    deliver    = 1'b0;
    frame_bad  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          rate_next  = RATE_HALF;
          state_next = START;
        end
      end
      START: begin
        rate_next = rate - 1'b1;
        if (tick) begin
          if (rx_s) begin
            state_next = IDLE;
          end else begin
            rate_next  = RATE_FULL;
            index_next = '0;
            state_next = DATA;
          end
        end
      end
      DATA: begin
        rate_next = rate - 1'b1;
        if (tick) begin
          shift_next        = shift >> 1;
          shift_next[N-1]   = rx_s;
          rate_next         = RATE_FULL;
          index_next        = index + 1'b1;
          if (index == LAST_BIT) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        rate_next = rate - 1'b1;
        if (tick) begin
          if (rx_s) begin
            deliver    = 1'b1;
            state_next = IDLE;
          end else begin
            frame_bad  = 1'b1;
            state_next = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync          <= 2'b11;
      state         <= IDLE;
      rate          <= '0;
      index         <= '0;
      shift         <= '0;
      data_valid    <= 1'b0;
      data_bits     <= '0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      sync          <= {sync[0], rx};
      state         <= state_next;
      rate          <= rate_next;
      index         <= index_next;
      shift         <= shift_next;
      framing_error <= frame_bad;
      overrun       <= deliver && !load;
      if (load) begin
        data_bits  <= shift;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule
